// File: rtl/gpio_mux_irq_if.sv
// APB slave port bundle for gpio_mux_irq.
//   psel/penable/pwrite/paddr/pwdata : requester -> block
//   prdata/pready/pslverr            : block -> requester
interface gpio_mux_irq_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/gpio_mux_irq.sv
// GPIO pad mux with per-pin edge/level interrupts.
//
// gpio_mux_irq_lane : one pad -- input synchroniser, edge history, sticky
//                     edge status and the function-select output mux.
// gpio_mux_irq      : APB register file, FSEL storage, level qualification
//                     and the registered irq.
//
// Ports (top):
//   clk, rst_n        clock, async active-low reset
//   apbs              APB slave (zero wait state, pslverr on unmapped offsets)
//   alt_out/alt_oe    peripheral drive/enable, fn f pad g at (f-1)*N_GPIO+g
//   gpio_in           synchronised pad inputs
//   padout_gpio/padoe_gpio  pad drive and enable
//   padin_gpio        raw asynchronous pad inputs
//   irq               registered interrupt request

module gpio_mux_irq_lane #(
  parameter int N_FUNC = 4,
  parameter int FW     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pad_in,
  input  logic              out_bit,
  input  logic              oe_bit,
  input  logic [FW-1:0]     fsel,
  input  logic [N_FUNC-2:0] alt_out,
  input  logic [N_FUNC-2:0] alt_oe,
  input  logic              edge_rise,
  input  logic              edge_fall,
  input  logic              w1c,
  output logic              gpio_in,
  output logic              sticky,
  output logic              padout,
  output logic              padoe
);
  logic meta, prev, set;

  // Edge detect runs on the synchronised value against its one-cycle-old copy.
  assign set = (edge_rise &  gpio_in & ~prev) |
               (edge_fall & ~gpio_in &  prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta    <= 1'b0;
      gpio_in <= 1'b0;
      prev    <= 1'b0;
      sticky  <= 1'b0;
    end else begin
      meta    <= pad_in;
      gpio_in <= meta;
      prev    <= gpio_in;
      // A new qualifying edge in the clearing cycle must not be lost.
      sticky  <= (sticky & ~w1c) | set;
    end
  end

  always_comb begin
    padout = out_bit;
    padoe  = oe_bit;
    for (int f = 1; f < N_FUNC; f++) begin
      if (fsel == FW'(f)) begin
        padout = alt_out[f-1];
        padoe  = alt_oe[f-1];
      end
    end
  end
endmodule

module gpio_mux_irq #(
  parameter int N_GPIO = 16,
  parameter int N_FUNC = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  gpio_mux_irq_if.slave                apbs,
  input  logic [N_GPIO*(N_FUNC-1)-1:0] alt_out,
  input  logic [N_GPIO*(N_FUNC-1)-1:0] alt_oe,
  output logic [N_GPIO-1:0]            gpio_in,
  output logic [N_GPIO-1:0]            padout_gpio,
  output logic [N_GPIO-1:0]            padoe_gpio,
  input  logic [N_GPIO-1:0]            padin_gpio,
  output logic                         irq
);
  localparam int FW  = $clog2(N_FUNC);
  localparam int PPW = 32 / FW;                 // pads per FSEL word
  localparam int NFW = (N_GPIO * FW + 31) / 32; // FSEL word count

  localparam logic [5:0] A_OUT     = 6'd0;
  localparam logic [5:0] A_OUT_XOR = 6'd1;
  localparam logic [5:0] A_OUT_SET = 6'd2;
  localparam logic [5:0] A_OUT_CLR = 6'd3;
  localparam logic [5:0] A_OE      = 6'd4;
  localparam logic [5:0] A_OE_XOR  = 6'd5;
  localparam logic [5:0] A_OE_SET  = 6'd6;
  localparam logic [5:0] A_OE_CLR  = 6'd7;
  localparam logic [5:0] A_IN      = 6'd8;
  localparam logic [5:0] A_STAT    = 6'd9;
  localparam logic [5:0] A_IE      = 6'd10;
  localparam logic [5:0] A_ER      = 6'd11;
  localparam logic [5:0] A_EF      = 6'd12;
  localparam logic [5:0] A_LH      = 6'd13;
  localparam logic [5:0] A_LL      = 6'd14;
  localparam logic [5:0] A_FSEL    = 6'd16;

  logic [N_GPIO-1:0]         out_q, oe_q, ie_q, er_q, ef_q, lh_q, ll_q;
  logic [N_GPIO-1:0][FW-1:0] fsel_q;
  logic [N_GPIO-1:0]         sticky, status, w1c, wd, rsel;
  logic [31:0]               rdata;
  logic [5:0]                idx;
  logic                      fsel_hit, mapped, acc, wr;
  logic                      irq_q;

  logic [N_GPIO-1:0][N_FUNC-2:0] lane_ao, lane_aoe;

  // Only paddr[7:2] is decoded; the rest of the address and any write data
  // above the implemented pads are don't-care.
  logic unused_apb;
  assign unused_apb = ^{apbs.paddr[15:8], apbs.paddr[1:0], apbs.pwdata};

  assign idx      = apbs.paddr[7:2];
  assign fsel_hit = (idx >= A_FSEL) && (idx < A_FSEL + 6'(NFW));
  assign mapped   = (idx <= A_LL) || fsel_hit;
  assign acc      = apbs.psel & apbs.penable;
  assign wr       = acc & apbs.pwrite & mapped;
  assign wd       = apbs.pwdata[N_GPIO-1:0];
  assign w1c      = (wr && idx == A_STAT) ? wd : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      oe_q   <= '0;
      ie_q   <= '0;
      er_q   <= '0;
      ef_q   <= '0;
      lh_q   <= '0;
      ll_q   <= '0;
      fsel_q <= '0;
    end else if (wr) begin
      case (idx)
        A_OUT:     out_q <= wd;
        A_OUT_XOR: out_q <= out_q ^ wd;
        A_OUT_SET: out_q <= out_q | wd;
        A_OUT_CLR: out_q <= out_q & ~wd;
        A_OE:      oe_q  <= wd;
        A_OE_XOR:  oe_q  <= oe_q ^ wd;
        A_OE_SET:  oe_q  <= oe_q | wd;
        A_OE_CLR:  oe_q  <= oe_q & ~wd;
        A_IE:      ie_q  <= wd;
        A_ER:      er_q  <= wd;
        A_EF:      ef_q  <= wd;
        A_LH:      lh_q  <= wd;
        A_LL:      ll_q  <= wd;
        default:   ;
      endcase
      for (int g = 0; g < N_GPIO; g++)
        if (idx == A_FSEL + 6'(g / PPW))
          fsel_q[g] <= apbs.pwdata[(g % PPW) * FW +: FW];
    end
  end

  // Level terms are live and bypass the sticky bits, so W1C cannot clear them.
  assign status = sticky | (gpio_in & lh_q) | (~gpio_in & ll_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= |(status & ie_q);
  end
  assign irq = irq_q;

  // Aliases read back the base register.
  always_comb begin
    rsel = '0;
    case (idx)
      A_OUT, A_OUT_XOR, A_OUT_SET, A_OUT_CLR: rsel = out_q;
      A_OE, A_OE_XOR, A_OE_SET, A_OE_CLR:     rsel = oe_q;
      A_IN:    rsel = gpio_in;
      A_STAT:  rsel = status;
      A_IE:    rsel = ie_q;
      A_ER:    rsel = er_q;
      A_EF:    rsel = ef_q;
      A_LH:    rsel = lh_q;
      A_LL:    rsel = ll_q;
      default: rsel = '0;
    endcase
    rdata = 32'(rsel);
    for (int g = 0; g < N_GPIO; g++)
      if (idx == A_FSEL + 6'(g / PPW))
        rdata[(g % PPW) * FW +: FW] = fsel_q[g];
  end

  assign apbs.prdata  = apbs.psel ? rdata : '0;
  assign apbs.pready  = 1'b1;
  assign apbs.pslverr = acc & ~mapped;

  // Regroup the function-major alt buses into per-pad vectors.
  for (genvar g = 0; g < N_GPIO; g++) begin : g_lane
    for (genvar f = 0; f < N_FUNC - 1; f++) begin : g_alt
      assign lane_ao[g][f]  = alt_out[f * N_GPIO + g];
      assign lane_aoe[g][f] = alt_oe[f * N_GPIO + g];
    end

    gpio_mux_irq_lane #(
      .N_FUNC (N_FUNC),
      .FW     (FW)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .pad_in    (padin_gpio[g]),
      .out_bit   (out_q[g]),
      .oe_bit    (oe_q[g]),
      .fsel      (fsel_q[g]),
      .alt_out   (lane_ao[g]),
      .alt_oe    (lane_aoe[g]),
      .edge_rise (er_q[g]),
      .edge_fall (ef_q[g]),
      .w1c       (w1c[g]),
      .gpio_in   (gpio_in[g]),
      .sticky    (sticky[g]),
      .padout    (padout_gpio[g]),
      .padoe     (padoe_gpio[g])
    );
  end
endmodule

// File: tb/tb_gpio_mux_irq.sv
module tb_gpio_mux_irq;
  localparam int NG = 16;
  localparam int NR = 200;

  logic        clk, rst_n;
  logic [47:0] alt_out, alt_oe;
  logic [15:0] gpio_in, padout, padoe, padin;
  logic        irq;

  gpio_mux_irq_if bus();

  gpio_mux_irq #(.N_GPIO(16), .N_FUNC(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .apbs        (bus),
    .alt_out     (alt_out),
    .alt_oe      (alt_oe),
    .gpio_in     (gpio_in),
    .padout_gpio (padout),
    .padoe_gpio  (padoe),
    .padin_gpio  (padin),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [15:0] a, input logic [31:0] d,
                      output logic [31:0] r, output logic e);
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = w; bus.paddr = a; bus.pwdata = d;
    @(negedge clk);
    bus.penable = 1'b1;
    #1;
    r = bus.prdata;
    e = bus.pslverr;
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic e;
    xfer(1'b1, a, d, r, e);
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] r);
    logic e;
    xfer(1'b0, a, 32'h0, r, e);
  endtask

  typedef struct {
    logic [15:0] waddr;
    logic [31:0] wdata;
    logic        werr;
    logic [15:0] raddr;
    logic [31:0] rexp;
  } vec_t;

  vec_t tbl[16];

  logic [31:0] r;
  logic        e;
  logic [15:0] o, oe_v, eo, eoe, pv, er, ef, lh, ll, ie, sticky, stat_prev, set, gin, w1c_now;
  logic [31:0] fs;
  logic [47:0] ao, aoe;
  logic        irq_exp;
  logic [15:0] hist [0:NR+3];

  initial begin
    tbl[0]  = '{16'h00, 32'h0000_00F0, 1'b0, 16'h00, 32'h0000_00F0};
    tbl[1]  = '{16'h10, 32'h0000_00FF, 1'b0, 16'h10, 32'h0000_00FF};
    tbl[2]  = '{16'h04, 32'h0000_0011, 1'b0, 16'h00, 32'h0000_00E1};
    tbl[3]  = '{16'h08, 32'h0000_0100, 1'b0, 16'h00, 32'h0000_01E1};
    tbl[4]  = '{16'h0C, 32'h0000_0080, 1'b0, 16'h0C, 32'h0000_0161};
    tbl[5]  = '{16'h14, 32'h0000_F00F, 1'b0, 16'h18, 32'h0000_F0F0};
    tbl[6]  = '{16'h1C, 32'h0000_00F0, 1'b0, 16'h10, 32'h0000_F000};
    tbl[7]  = '{16'h18, 32'hFFFF_000F, 1'b0, 16'h14, 32'h0000_F00F};
    tbl[8]  = '{16'h2C, 32'hFFFF_FFFF, 1'b0, 16'h2C, 32'h0000_FFFF};
    tbl[9]  = '{16'h2C, 32'h0000_0000, 1'b0, 16'h2C, 32'h0000_0000};
    tbl[10] = '{16'h3C, 32'h0000_1234, 1'b1, 16'h3C, 32'h0000_0000};
    tbl[11] = '{16'h80, 32'h0000_FFFF, 1'b1, 16'h00, 32'h0000_0161};
    tbl[12] = '{16'h20, 32'h0000_FFFF, 1'b0, 16'h20, 32'h0000_0000};
    tbl[13] = '{16'h40, 32'h5555_5555, 1'b0, 16'h40, 32'h5555_5555};
    tbl[14] = '{16'h40, 32'h0000_0000, 1'b0, 16'h40, 32'h0000_0000};
    tbl[15] = '{16'h44, 32'h0000_0001, 1'b1, 16'h44, 32'h0000_0000};

    rst_n = 1'b0; padin = '0; alt_out = '0; alt_oe = '0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst padoe", 32'(padoe), 32'h0);
    chk("rst padout", 32'(padout), 32'h0);
    chk("rst irq", 32'(irq), 32'h0);
    chk("rst prdata", bus.prdata, 32'h0);
    chk("rst pslverr", 32'(bus.pslverr), 32'h0);
    chk("rst pready", 32'(bus.pready), 32'h1);
    rst_n = 1'b1;
    for (int a = 0; a <= 16'h40; a += 4) begin
      if (a != 16'h3C) begin
        rd(16'(a), r);
        chk($sformatf("rst reg %h", a), r, 32'h0);
      end
    end

    // Register table
    for (int i = 0; i < 16; i++) begin
      xfer(1'b1, tbl[i].waddr, tbl[i].wdata, r, e);
      chk($sformatf("tbl%0d pslverr", i), 32'(e), 32'(tbl[i].werr));
      xfer(1'b0, tbl[i].raddr, 32'h0, r, e);
      chk($sformatf("tbl%0d rdata", i), r, tbl[i].rexp);
    end
    chk("padout low byte", 32'(padout[7:0]), 32'h61);
    wr(16'h10, 32'hFF);

    // Pad 3 -> function 2
    alt_out[NG+3] = 1'b1; alt_oe[NG+3] = 1'b1;
    wr(16'h40, 32'h80);
    chk("fsel2 padout3", 32'(padout[3]), 32'h1);
    chk("fsel2 padoe3", 32'(padoe[3]), 32'h1);
    wr(16'h40, 32'h0);
    chk("fsel0 padout3", 32'(padout[3]), 32'h0);
    chk("fsel0 padoe3", 32'(padoe[3]), 32'h1);

    // Random pad mux
    for (int it = 0; it < 20; it++) begin
      o = 16'($urandom); oe_v = 16'($urandom); fs = $urandom;
      ao = 48'({$urandom, $urandom}); aoe = 48'({$urandom, $urandom});
      alt_out = ao; alt_oe = aoe;
      wr(16'h00, 32'(o)); wr(16'h10, 32'(oe_v)); wr(16'h40, fs);
      for (int g = 0; g < NG; g++) begin
        int f;
        f = int'((fs >> (2 * g)) & 32'h3);
        if (f == 0) begin eo[g] = o[g]; eoe[g] = oe_v[g]; end
        else begin eo[g] = ao[(f - 1) * NG + g]; eoe[g] = aoe[(f - 1) * NG + g]; end
      end
      chk("mux padout", 32'(padout), 32'(eo));
      chk("mux padoe", 32'(padoe), 32'(eoe));
    end
    alt_out = '0; alt_oe = '0;
    wr(16'h40, 32'h0);

    // Rising edge on pad 0: sticky at k+2, irq at k+3
    wr(16'h2C, 32'h1); wr(16'h28, 32'h1);
    @(negedge clk); padin[0] = 1'b1;
    @(posedge clk); #1 chk("edge gpio_in k", 32'(gpio_in[0]), 32'h0);
    @(posedge clk); #1 chk("edge gpio_in k+1", 32'(gpio_in[0]), 32'h1);
    chk("edge irq k+1", 32'(irq), 32'h0);
    @(posedge clk); #1 chk("edge irq k+2", 32'(irq), 32'h0);
    @(posedge clk); #1 chk("edge irq k+3", 32'(irq), 32'h1);
    rd(16'h24, r); chk("edge status", r, 32'h1);

    // W1C drops irq one cycle after the write edge
    wr(16'h24, 32'h1);
    chk("w1c irq at W", 32'(irq), 32'h1);
    @(posedge clk); #1 chk("w1c irq W+1", 32'(irq), 32'h0);
    rd(16'h24, r); chk("w1c status", r, 32'h0);

    // W1C and new rising edge on the same edge: set wins
    @(negedge clk); padin[0] = 1'b0;
    repeat (4) @(negedge clk);
    padin[0] = 1'b1;
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 16'h24; bus.pwdata = 32'h1;
    @(negedge clk); bus.penable = 1'b1;
    @(negedge clk); bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    rd(16'h24, r); chk("w1c vs set", r, 32'h1);
    wr(16'h24, 32'h1);

    // Level-low source on pad 2
    wr(16'h38, 32'h4); wr(16'h28, 32'h4);
    repeat (2) @(negedge clk);
    chk("level irq", 32'(irq), 32'h1);
    rd(16'h24, r); chk("level status", r, 32'h4);
    wr(16'h24, 32'h4);
    repeat (2) @(negedge clk);
    chk("level irq after w1c", 32'(irq), 32'h1);
    rd(16'h24, r); chk("level status after w1c", r, 32'h4);
    @(negedge clk); padin[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 chk("level irq k+1", 32'(irq), 32'h1);
    @(posedge clk); #1 chk("level irq k+2", 32'(irq), 32'h0);

    // Randomised interrupt traffic against a pad-history model
    pv = 16'($urandom); padin = pv;
    repeat (5) @(negedge clk);
    er = 16'($urandom); ef = 16'($urandom); ie = 16'($urandom);
    lh = 16'($urandom & $urandom & $urandom); ll = 16'($urandom & $urandom & $urandom);
    wr(16'h2C, 32'(er)); wr(16'h30, 32'(ef)); wr(16'h34, 32'(lh));
    wr(16'h38, 32'(ll)); wr(16'h28, 32'(ie)); wr(16'h24, 32'hFFFF);
    for (int i = 0; i < 3; i++) hist[i] = pv;
    sticky = '0;
    stat_prev = (pv & lh) | (~pv & ll);
    for (int n = 3; n < NR + 3; n++) begin
      w1c_now = '0;
      if (n < NR - 3) pv = pv ^ 16'($urandom & $urandom & $urandom);
      if (bus.psel && bus.penable) begin
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
      end else if (bus.psel) begin
        bus.penable = 1'b1; w1c_now = bus.pwdata[15:0];
      end else if (n % 20 == 0 && n < NR - 6) begin
        bus.psel = 1'b1; bus.pwrite = 1'b1; bus.paddr = 16'h24; bus.pwdata = $urandom;
      end
      hist[n] = pv; padin = pv;
      @(posedge clk);
      set = (hist[n-2] & ~hist[n-3] & er) | (~hist[n-2] & hist[n-3] & ef);
      irq_exp = |(stat_prev & ie);
      sticky = (sticky & ~w1c_now) | set;
      gin = hist[n-1];
      stat_prev = sticky | (gin & lh) | (~gin & ll);
      #1;
      chk("rnd gpio_in", 32'(gpio_in), 32'(gin));
      chk("rnd irq", 32'(irq), 32'(irq_exp));
      @(negedge clk);
    end
    rd(16'h24, r); chk("rnd status", r, 32'(stat_prev));
    rd(16'h20, r); chk("rnd IN", r, 32'(pv));

    // Reset mid-operation, no clock edge needed
    wr(16'h00, 32'hFFFF); wr(16'h10, 32'hFFFF); wr(16'h34, 32'hFFFF); wr(16'h28, 32'hFFFF);
    padin = 16'hFFFF;
    repeat (4) @(negedge clk);
    chk("pre-reset padout", 32'(padout), 32'hFFFF);
    chk("pre-reset irq", 32'(irq), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst padout", 32'(padout), 32'h0);
    chk("async rst padoe", 32'(padoe), 32'h0);
    chk("async rst irq", 32'(irq), 32'h0);
    chk("async rst gpio_in", 32'(gpio_in), 32'h0);
    padin = '0;
    @(negedge clk); rst_n = 1'b1;
    rd(16'h00, r); chk("post-reset OUT", r, 32'h0);
    rd(16'h28, r); chk("post-reset IE", r, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
